// File: rtl/prbs_gen_multi_if.sv
// rtl/prbs_gen_multi_if.sv - symbol stream handshake between the PRBS source and its consumer
interface prbs_gen_multi_if #(
  parameter int BITS_PER_SYM = 4
);
  logic [BITS_PER_SYM-1:0] out_bits;
  logic                    out_valid;
  logic                    out_ready;

  modport master (output out_bits, output out_valid, input out_ready);
  modport slave  (input out_bits, input out_valid, output out_ready);
endinterface

// File: rtl/prbs_gen_multi.sv
// rtl/prbs_gen_multi.sv - runtime-selectable PRBS-7/15/23/31 symbol source with backpressure
// Optional single-bit error injection is built when PRBS_ERR_INJ_EN is defined.
module prbs_gen_multi #(
  parameter int BITS_PER_SYM = 4,
  parameter int RESET_MODE   = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [1:0]           mode_sel,
  input  logic                 seed_load,
  input  logic [30:0]          seed_in,
  output logic [CNT_WIDTH-1:0] sym_cnt,
  output logic [1:0]           mode_q,
  input  logic                 err_inj,
  prbs_gen_multi_if.master     sym_if
);
  localparam int N = BITS_PER_SYM;

  typedef enum logic {IDLE, RUN} fsm_t;

  function automatic logic [30:0] poly_mask(input logic [1:0] m);
    case (m)
      2'd0:    return 31'h0000007F;
      2'd1:    return 31'h00007FFF;
      2'd2:    return 31'h007FFFFF;
      default: return 31'h7FFFFFFF;
    endcase
  endfunction

  function automatic logic [4:0] poly_msb(input logic [1:0] m);
    case (m)
      2'd0:    return 5'd6;
      2'd1:    return 5'd14;
      2'd2:    return 5'd22;
      default: return 5'd30;
    endcase
  endfunction

  function automatic logic poly_fb(input logic [30:0] s, input logic [1:0] m);
    case (m)
      2'd0:    return s[6] ^ s[5];
      2'd1:    return s[14] ^ s[13];
      2'd2:    return s[22] ^ s[17];
      default: return s[30] ^ s[27];
    endcase
  endfunction

  fsm_t                 fsm_q, fsm_d;
  logic [30:0]          state_q, state_d;
  logic [1:0]           mode_d;
  logic [N-1:0]         out_bits_q, out_bits_d;
  logic                 out_valid_q, out_valid_d;
  logic [CNT_WIDTH-1:0] sym_cnt_q, sym_cnt_d;
  logic                 produce, accept;
  logic [30:0]          walk, seed_masked;
  logic [N-1:0]         sym_bits, sym_tx;
  logic                 inj_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm_q <= IDLE;
    else        fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (en)  fsm_d = RUN;
      default: if (!en) fsm_d = IDLE;
    endcase
  end

  // en gates only new production; a presented symbol waits for ready regardless.
  always_comb begin
    produce = (fsm_q == RUN || en) && en && (!out_valid_q || sym_if.out_ready);
    accept  = out_valid_q && sym_if.out_ready;
  end

  // Unrolled symbol: output bit is the polynomial MSB before each of the N steps.
  always_comb begin
    walk = state_q & poly_mask(mode_q);
    if (walk == '0) walk = poly_mask(mode_q);
    sym_bits = '0;
    for (int k = 0; k < N; k++) begin
      sym_bits[N-1-k] = walk[poly_msb(mode_q)];
      walk = {walk[29:0], poly_fb(walk, mode_q)} & poly_mask(mode_q);
    end
  end

`ifdef PRBS_ERR_INJ_EN
  logic err_pend_q, err_pend_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_pend_q <= 1'b0;
    else        err_pend_q <= err_pend_d;
  end

  always_comb begin
    inj_now    = produce && (err_pend_q || err_inj);
    err_pend_d = err_pend_q || err_inj;
    if (seed_load)    err_pend_d = 1'b0;
    else if (inj_now) err_pend_d = 1'b0;
  end
`else
  logic err_inj_unused;
  assign err_inj_unused = err_inj;
  assign inj_now        = 1'b0;
`endif

  always_comb begin
    sym_tx    = sym_bits;
    sym_tx[0] = sym_bits[0] ^ inj_now;
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    out_bits_d  = out_bits_q;
    out_valid_d = out_valid_q;
    sym_cnt_d   = sym_cnt_q;
    seed_masked = seed_in & poly_mask(mode_sel);
    if (seed_load) begin
      state_d     = (seed_masked == '0) ? poly_mask(mode_sel) : seed_masked;
      mode_d      = mode_sel;
      out_valid_d = 1'b0;
      sym_cnt_d   = '0;
    end else begin
      if (accept) sym_cnt_d = sym_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      if (produce) begin
        out_bits_d  = sym_tx;
        out_valid_d = 1'b1;
        state_d     = walk;
      end else if (accept) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= '1;
      mode_q      <= 2'(RESET_MODE);
      out_bits_q  <= '0;
      out_valid_q <= 1'b0;
      sym_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      out_bits_q  <= out_bits_d;
      out_valid_q <= out_valid_d;
      sym_cnt_q   <= sym_cnt_d;
    end
  end

  assign sym_if.out_bits  = out_bits_q;
  assign sym_if.out_valid = out_valid_q;
  assign sym_cnt          = sym_cnt_q;
endmodule
